// File: rtl/mdu_iter_div_if.sv
// mdu_iter_div_if: handshake and data bundle between the EX stage and the
// iterative divider. The EX stage drives the master side; the divider
// implements the slave side.
interface mdu_iter_div_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               annul;
    logic               ready;
    logic               stallreq_for_ex;
    logic               result_valid;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  ready, stallreq_for_ex, result_valid, result
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output ready, stallreq_for_ex, result_valid, result
    );
endinterface

// File: rtl/mdu_iter_div.sv
// mdu_iter_div: parametrised iterative restoring divider for the EX stage.
// One quotient bit is produced per cycle, MSB first. Signed operands are
// reduced to magnitudes when the divide is accepted and the signs are put
// back when the result is registered, so the core loop is purely unsigned.
// The result is {remainder, quotient}, matching the HI/LO write-back.
// Optional build macro: DIV_EARLY_OUT_EN adds a one-cycle finish when the
// dividend magnitude is already smaller than the divisor magnitude.
module mdu_iter_div #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mdu_iter_div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Control and output registers
    state_t             state_q;
    logic               ready_q;
    logic               valid_q;
    logic [2*WIDTH-1:0] result_q;
    logic [CNT_W-1:0]   cnt_q;

    // Datapath registers: the dividend register shifts out its MSB each step
    // and the new quotient bit enters at its LSB, so after WIDTH steps it
    // holds the unsigned quotient.
    logic [WIDTH-1:0]   divisorMag_q;
    logic [WIDTH-1:0]   dividend_q;
    logic [WIDTH-1:0]   partial_q;
    logic               quoNeg_q;
    logic               remNeg_q;

    // Combinational helpers
    logic [WIDTH-1:0]   opAMag;
    logic [WIDTH-1:0]   opBMag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               quoBit;
    logic [WIDTH-1:0]   partial_d;
    logic [WIDTH-1:0]   dividend_d;
    logic [WIDTH-1:0]   finalQuo;
    logic [WIDTH-1:0]   finalRem;
    logic               earlyOut;
    logic               accept;

    // Operand magnitudes, one restoring step, and the sign-corrected final values.
    // The partial remainder stays below the divisor, so it fits in WIDTH bits;
    // only the shifted value needs the extra bit for the compare.
    always_comb begin
        opAMag = bus.opdata1;
        opBMag = bus.opdata2;
        if (bus.signed_div && bus.opdata1[WIDTH-1]) begin
            opAMag = -bus.opdata1;
        end
        if (bus.signed_div && bus.opdata2[WIDTH-1]) begin
            opBMag = -bus.opdata2;
        end

        accept     = (state_q == IDLE) && bus.start && !bus.annul;

        shifted    = {partial_q, dividend_q[WIDTH-1]};
        quoBit     = (shifted >= {1'b0, divisorMag_q});
        diff       = shifted[WIDTH-1:0] - divisorMag_q;
        partial_d  = quoBit ? diff : shifted[WIDTH-1:0];
        dividend_d = {dividend_q[WIDTH-2:0], quoBit};

        finalQuo   = quoNeg_q ? -dividend_d : dividend_d;
        finalRem   = remNeg_q ? -partial_d : partial_d;

`ifdef DIV_EARLY_OUT_EN
        earlyOut   = (opAMag < opBMag);
`else
        earlyOut   = 1'b0;
`endif
    end

    // Control FSM and datapath: accept, iterate, present the result for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            result_q     <= '0;
            cnt_q        <= '0;
            divisorMag_q <= '0;
            dividend_q   <= '0;
            partial_q    <= '0;
            quoNeg_q     <= 1'b0;
            remNeg_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.opdata2 == '0) begin
                            state_q  <= DONE;
                            ready_q  <= 1'b0;
                            valid_q  <= 1'b1;
                            result_q <= {bus.opdata1, {WIDTH{1'b1}}};
                        end else if (earlyOut) begin
                            state_q  <= DONE;
                            ready_q  <= 1'b0;
                            valid_q  <= 1'b1;
                            result_q <= {bus.opdata1, {WIDTH{1'b0}}};
                        end else begin
                            state_q      <= BUSY;
                            ready_q      <= 1'b0;
                            divisorMag_q <= opBMag;
                            dividend_q   <= opAMag;
                            partial_q    <= '0;
                            cnt_q        <= '0;
                            quoNeg_q     <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                            remNeg_q     <= bus.signed_div & bus.opdata1[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    if (bus.annul) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        dividend_q <= dividend_d;
                        partial_q  <= partial_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= {finalRem, finalQuo};
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // A flush in the presentation cycle suppresses the pulse; EX is released
    // in DONE so it can advance while the result is on the bus.
    always_comb begin
        bus.ready           = ready_q;
        bus.result          = result_q;
        bus.result_valid    = valid_q & ~bus.annul;
        bus.stallreq_for_ex = accept || (state_q == BUSY);
    end
endmodule

// File: tb/tb_mdu_iter_div.sv
// tb_mdu_iter_div: self-checking bench for mdu_iter_div at WIDTH=32 and
// WIDTH=8. A cycle-level reference model built on plain integer division
// predicts ready, stall, result_valid and result for every cycle; directed
// vectors add hand-computed latency and result expectations.
// Honours DIV_EARLY_OUT_EN for the expected latency of short divides.
module tb_mdu_iter_div;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    bit           mKnown [2];
    bit           mIdle  [2];
    int           mDone  [2];
    logic [127:0] mExp   [2];
    logic [127:0] mLast  [2];

    mdu_iter_div_if #(.WIDTH(32)) bus32 ();
    mdu_iter_div_if #(.WIDTH(8))  bus8 ();

    mdu_iter_div #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    mdu_iter_div #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] widthMask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] magOf(input int w, input bit sgn, input logic [63:0] v);
        logic [63:0] m;
        m = widthMask(w);
        if (sgn && v[w-1]) return (~v + 64'd1) & m;
        return v & m;
    endfunction

    // Reference divide: {remainder, quotient} packed as (rem << w) | quo
    function automatic logic [127:0] refDiv(input int w, input bit sgn,
                                            input logic [63:0] aIn, input logic [63:0] bIn);
        logic [63:0] m;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        m = widthMask(w);
        a = aIn & m;
        b = bIn & m;
        if (b == 64'd0) begin
            q = longint'(m);
            r = longint'(a);
        end else if (sgn) begin
            sa = a[w-1] ? longint'(a | ~m) : longint'(a);
            sb = b[w-1] ? longint'(b | ~m) : longint'(b);
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = longint'(a / b);
            r = longint'(a % b);
        end
        return (128'(r & m) << w) | 128'(q & m);
    endfunction

    // Cycles from the accepting edge to the presentation cycle
    function automatic int refLat(input int w, input bit sgn,
                                  input logic [63:0] a, input logic [63:0] b);
        if ((b & widthMask(w)) == 64'd0) return 1;
        if (EARLY && (magOf(w, sgn, a) < magOf(w, sgn, b))) return 1;
        return w + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle model step: check this cycle's outputs, then advance on this cycle's inputs
    task automatic compareInst(input int k, input int w, input logic rstIn,
                               input logic startIn, input logic annulIn, input logic sgnIn,
                               input logic [63:0] aIn, input logic [63:0] bIn,
                               input logic readyIn, input logic stallIn,
                               input logic validIn, input logic [127:0] resultIn);
        bit    doneNow;
        bit    expStall;
        string tag;
        tag = (k == 0) ? "w32" : "w8";
        if (!mKnown[k]) begin
            if (rstIn === 1'b1) begin
                mKnown[k] = 1'b1;
                mIdle[k]  = 1'b1;
                mLast[k]  = '0;
            end
            return;
        end
        doneNow  = !mIdle[k] && (cyc == mDone[k]);
        expStall = mIdle[k] ? (startIn && !annulIn) : (cyc < mDone[k]);
        checkOutput({tag, " ready"}, 128'(readyIn), 128'(mIdle[k]));
        checkOutput({tag, " stallreq"}, 128'(stallIn), 128'(expStall));
        checkOutput({tag, " result_valid"}, 128'(validIn), 128'(doneNow && !annulIn));
        checkOutput({tag, " result"}, resultIn, doneNow ? mExp[k] : mLast[k]);
        if (rstIn) begin
            mIdle[k] = 1'b1;
            mLast[k] = '0;
        end else if (mIdle[k]) begin
            if (startIn && !annulIn) begin
                mIdle[k] = 1'b0;
                mDone[k] = cyc + refLat(w, sgnIn, aIn, bIn);
                mExp[k]  = refDiv(w, sgnIn, aIn, bIn);
            end
        end else begin
            if (doneNow) mLast[k] = mExp[k];
            if (annulIn || doneNow) mIdle[k] = 1'b1;
        end
    endtask

    // Model compare on the falling edge, away from the active edge
    always @(negedge clk) begin
        compareInst(0, 32, rst, bus32.start, bus32.annul, bus32.signed_div,
                    64'(bus32.opdata1), 64'(bus32.opdata2), bus32.ready,
                    bus32.stallreq_for_ex, bus32.result_valid, 128'(bus32.result));
        compareInst(1, 8, rst, bus8.start, bus8.annul, bus8.signed_div,
                    64'(bus8.opdata1), 64'(bus8.opdata2), bus8.ready,
                    bus8.stallreq_for_ex, bus8.result_valid, 128'(bus8.result));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveInputs(input int k, input logic s, input logic an, input logic sg,
                               input logic [63:0] a, input logic [63:0] b);
        if (k == 0) begin
            bus32.start      = s;
            bus32.annul      = an;
            bus32.signed_div = sg;
            bus32.opdata1    = a[31:0];
            bus32.opdata2    = b[31:0];
        end else begin
            bus8.start      = s;
            bus8.annul      = an;
            bus8.signed_div = sg;
            bus8.opdata1    = a[7:0];
            bus8.opdata2    = b[7:0];
        end
    endtask

    // One-cycle start pulse; c0 is the cycle in which start is presented
    task automatic applyStimulus(input int k, input logic sg, input logic [63:0] a,
                                 input logic [63:0] b, output int c0);
        driveInputs(k, 1'b1, 1'b0, sg, a, b);
        c0 = cyc;
        tick();
        driveInputs(k, 1'b0, 1'b0, sg, a, b);
    endtask

    // Bounded wait for result_valid, then check latency, result and stall release
    task automatic waitResult(input int k, input string name, input int c0,
                              input int expLat, input logic [127:0] expRes);
        bit           seen;
        int           vc;
        logic [127:0] res;
        logic         stallAtValid;
        seen = 1'b0;
        vc = 0;
        res = '0;
        stallAtValid = 1'b1;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if ((k == 0) ? bus32.result_valid : bus8.result_valid) begin
                seen         = 1'b1;
                vc           = cyc;
                res          = (k == 0) ? 128'(bus32.result) : 128'(bus8.result);
                stallAtValid = (k == 0) ? bus32.stallreq_for_ex : bus8.stallreq_for_ex;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no result_valid, expected one within 80 cycles", name);
        end else begin
            checkOutput({name, " latency"}, 128'(vc - c0), 128'(expLat));
            checkOutput({name, " result"}, res, expRes);
            checkOutput({name, " stall in DONE"}, 128'(stallAtValid), '0);
        end
        tick();
    endtask

    task automatic runVec(input int k, input string name, input logic sg, input logic [63:0] a,
                          input logic [63:0] b, input int expLat, input logic [127:0] expRes);
        int c0;
        applyStimulus(k, sg, a, b, c0);
        waitResult(k, name, c0, expLat, expRes);
    endtask

    // Directed sequence
    initial begin
        int c0;
        int c1;
        driveInputs(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        driveInputs(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("reset ready", 128'(bus32.ready), 128'(1));
        checkOutput("reset result_valid", 128'(bus32.result_valid), '0);
        checkOutput("reset result", 128'(bus32.result), '0);
        checkOutput("reset stallreq", 128'(bus32.stallreq_for_ex), '0);

        $display("[TB] model pins");
        checkOutput("model 100/7", refDiv(32, 1'b0, 64'd100, 64'd7), 128'({32'd2, 32'd14}));
        checkOutput("model -127/3 w8", refDiv(8, 1'b1, 64'h81, 64'h03), 128'({8'hFF, 8'hD6}));
        checkOutput("model MIN/-1", refDiv(32, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF),
                    128'({32'h0, 32'h8000_0000}));

        $display("[TB] 32-bit directed divides");
        runVec(0, "u 100/7", 1'b0, 64'd100, 64'd7, 33, 128'({32'd2, 32'd14}));
        runVec(0, "s -7/2", 1'b1, 64'hFFFF_FFF9, 64'h0000_0002, 33,
               128'({32'hFFFF_FFFF, 32'hFFFF_FFFD}));
        runVec(0, "s MIN/-1", 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 33,
               128'({32'h0, 32'h8000_0000}));
        runVec(0, "u 5/0", 1'b0, 64'd5, 64'd0, 1, 128'({32'd5, 32'hFFFF_FFFF}));
        runVec(0, "s 7/-2", 1'b1, 64'd7, 64'hFFFF_FFFE, 33, 128'({32'd1, 32'hFFFF_FFFD}));
        runVec(0, "u 3/10", 1'b0, 64'd3, 64'd10, EARLY ? 1 : 33, 128'({32'd3, 32'd0}));

        $display("[TB] annul in BUSY");
        applyStimulus(0, 1'b0, 64'd1000, 64'd3, c0);
        while (cyc < c0 + 10) tick();
        driveInputs(0, 1'b0, 1'b1, 1'b0, 64'd1000, 64'd3);
        tick();
        driveInputs(0, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
        checkOutput("annul ready next cycle", 128'(bus32.ready), 128'(1));
        applyStimulus(0, 1'b0, 64'd9, 64'd3, c1);
        checkOutput("annul restart cycle", 128'(c1 - c0), 128'(11));
        waitResult(0, "after annul 9/3", c0, 44, 128'({32'd0, 32'd3}));

        $display("[TB] reset in BUSY");
        applyStimulus(0, 1'b0, 64'd1000, 64'd3, c0);
        while (cyc < c0 + 10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst ready next cycle", 128'(bus32.ready), 128'(1));
        checkOutput("rst result cleared", 128'(bus32.result), '0);
        applyStimulus(0, 1'b0, 64'd9, 64'd3, c1);
        waitResult(0, "after rst 9/3", c0, 44, 128'({32'd0, 32'd3}));

        $display("[TB] annul beats start in IDLE");
        driveInputs(0, 1'b1, 1'b1, 1'b0, 64'd20, 64'd4);
        #1;
        checkOutput("idle annul stallreq", 128'(bus32.stallreq_for_ex), '0);
        tick();
        driveInputs(0, 1'b0, 1'b0, 1'b0, 64'd20, 64'd4);
        checkOutput("idle annul stays ready", 128'(bus32.ready), 128'(1));
        repeat (3) tick();

        $display("[TB] 8-bit divides");
        applyStimulus(1, 1'b1, 64'h81, 64'h03, c0);
        tick();
        tick();
        driveInputs(1, 1'b1, 1'b0, 1'b0, 64'h10, 64'h00);
        tick();
        driveInputs(1, 1'b0, 1'b0, 1'b0, 64'h10, 64'h00);
        tick();
        driveInputs(1, 1'b1, 1'b0, 1'b1, 64'h55, 64'h01);
        tick();
        driveInputs(1, 1'b0, 1'b0, 1'b1, 64'h55, 64'h01);
        waitResult(1, "w8 s -127/3 busy starts", c0, 9, 128'({8'hFF, 8'hD6}));
        runVec(1, "w8 u 200/7", 1'b0, 64'd200, 64'd7, 9, 128'({8'd4, 8'd28}));
        runVec(1, "w8 s MIN/-1", 1'b1, 64'h80, 64'hFF, 9, 128'({8'h00, 8'h80}));
        runVec(1, "w8 s -2/5", 1'b1, 64'hFE, 64'h05, EARLY ? 1 : 9, 128'({8'hFE, 8'h00}));
        runVec(1, "w8 s -128/0", 1'b1, 64'h80, 64'h00, 1, 128'({8'h80, 8'hFF}));

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mdu_iter_div.md
Name: mdu_iter_div

Overview:
Parametrised iterative restoring divider for the EX stage; it generalises the fixed 32-bit HI/LO divide path to any operand width.
- Accepts one signed or unsigned divide at a time and raises a stall request to CTRL while it works.
- Returns {remainder, quotient} for the HI/LO write-back carried on the EX-to-MEM bus.
- Can be cancelled by a pipeline flush.

Parameters:
WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits; legal range 4..64
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
start  input  1  request a divide; sampled only in IDLE
signed_div  input  1  1 = two's-complement divide, 0 = unsigned
opdata1  input  WIDTH  dividend
opdata2  input  WIDTH  divisor
annul  input  1  cancel the operation in flight (pipeline flush)
ready  output  1  high in IDLE; a new start is accepted
stallreq_for_ex  output  1  stall request to CTRL
result_valid  output  1  one-cycle pulse; result is valid
result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]} (HI, LO)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, result_valid=0, result=0, stallreq_for_ex=0, counter=0.
- Reset mid-operation: the divide is aborted with no result_valid pulse.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, opdata2!=0:
  - latch the operand magnitudes (absolute values if signed_div=1, else raw).
  - latch sign_q = signed_div & (opdata1[WIDTH-1]^opdata2[WIDTH-1]) and sign_r = signed_div & opdata1[WIDTH-1].
  - clear the partial remainder; counter=0; go to BUSY.
- IDLE, start=1, opdata2==0: go directly to DONE with quotient={WIDTH{1'b1}} and remainder=opdata1 (raw, no sign fix).
- BUSY: one quotient bit per cycle, MSB first.
  - partial remainder shifts left by 1, taking in the next dividend bit.
  - if partial >= |divisor|, subtract and set the quotient bit to 1.
  - the compare and subtract are WIDTH+1 bits wide so there is no overflow.
  - after exactly WIDTH BUSY cycles (counter==WIDTH-1 on the last one), go to DONE.
- DONE, held for one cycle:
  - result_valid=1.
  - result = {sign_r ? -rem : rem, sign_q ? -quo : quo}, with WIDTH-bit wrap-around negation.
  - next state is IDLE.
  - result holds its value until the next DONE.
- Latency: start is sampled at edge 0 and result_valid is high in cycle WIDTH+1. Divide-by-zero completes in cycle 1.
- Throughput: the earliest next start is in the cycle after DONE; the block is never back-to-back with DONE.
- stallreq_for_ex is combinational:
  - high when (IDLE & start), or in BUSY;
  - low in DONE, so EX advances in the same cycle the result is presented.
- start outside IDLE is ignored, and the latched operands are unaffected.
- annul:
  - in BUSY or DONE, go to IDLE at the next edge; result_valid is forced to 0 in that cycle; result is not updated.
  - in IDLE, annul overrides a simultaneous start (the operation is not accepted and stallreq_for_ex=0).
- Signed overflow: MIN / -1 gives quotient=MIN (wraps) and remainder=0. There is no trap.
- Remainder magnitude is always < |divisor|, and the remainder sign follows the dividend.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, if start=1, divisor!=0 and |dividend| < |divisor| (magnitudes in the selected mode):
  - go directly to DONE with quotient=0 and remainder=opdata1 (raw);
  - result_valid is high in cycle 1;
  - stallreq_for_ex behaves as for the divide-by-zero path.
- Undefined: the compare logic is absent and every non-zero-divisor divide takes WIDTH BUSY cycles.

Test Plan:
- WIDTH=32, unsigned 100/7 -> result_valid in cycle 33; result={32'd2, 32'd14}; stallreq_for_ex high in cycles 0..32, low in 33.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 5/0 -> valid in cycle 1, quotient 0xFFFFFFFF, remainder 5.
- Start 1000/3, annul in cycle 10 -> no result_valid; ready=1 in cycle 11; a new start 9/3 gives quotient 3, remainder 0 in cycle 12+32; mid-op rst behaves the same.
- WIDTH=8, signed 0x81/0x03 (-127/3) -> valid in cycle 9; quotient 0xD6 (-42), remainder 0xFF (-1); start pulses during BUSY are ignored.
- Unsigned 3/10 -> valid in cycle 1 with {3, 0} when DIV_EARLY_OUT_EN is defined, otherwise valid in cycle 33 with the same result.
